// File: rtl/layer30_trainer_if.sv
// ============================================================================
// layer30_trainer_if : sample/result handshake and layer target-side bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface layer30_trainer_if #(
   parameter int DATA_W = 8
);
   logic                   sample_valid;
   logic                   sample_ready;
   logic [4:0]             sample_label;
   logic                   sample_train;
   logic                   layer_valid;
   logic                   layer_learn;
   logic [29:0][DATA_W-1:0] layer_out;
   logic [29:0][DATA_W-1:0] layer_expected_out;
   logic                   result_valid;
   logic [4:0]             result_pred;
   logic                   result_correct;
   logic                   result_label_err;
   logic                   clear_stats;
   logic [15:0]            sample_count;
   logic [15:0]            correct_count;

   // trainer side
   modport slave (
      input  sample_valid, sample_label, sample_train, layer_out, clear_stats,
      output sample_ready, layer_valid, layer_learn, layer_expected_out,
             result_valid, result_pred, result_correct, result_label_err,
             sample_count, correct_count
   );

   // sample source / layer side
   modport master (
      output sample_valid, sample_label, sample_train, layer_out, clear_stats,
      input  sample_ready, layer_valid, layer_learn, layer_expected_out,
             result_valid, result_pred, result_correct, result_label_err,
             sample_count, correct_count
   );
endinterface

`default_nettype wire

// File: rtl/layer30_trainer.sv
// ============================================================================
// layer30_trainer : argmax/learn sequencer for a 30-output layer
// Option macro: TRAINER_SKIP_CORRECT_EN (skip LEARN on correct prediction)
// Rev 1.0
// ============================================================================
`default_nettype none

module layer30_trainer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LEARN_CYCLES  = 1,
   parameter int DATA_W        = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   layer30_trainer_if.slave  bus
);
   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_DRIVE  = 3'd1;
   localparam logic [2:0] c_ST_SETTLE = 3'd2;
   localparam logic [2:0] c_ST_SCAN   = 3'd3;
   localparam logic [2:0] c_ST_LEARN  = 3'd4;
   localparam logic [2:0] c_ST_REPORT = 3'd5;

   logic [2:0]        r_state, w_next;
   logic [7:0]        r_cnt;
   logic              r_ready;
   logic [4:0]        r_label;
   logic              r_train;
   logic [DATA_W-1:0] r_max;
   logic [4:0]        r_idx;
   logic              r_res_valid, r_res_correct, r_res_err;
   logic [4:0]        r_res_pred;
   logic [15:0]       r_sample_count, r_correct_count;

   logic              w_accept, w_label_ok, w_scan_last, w_gt, w_do_learn;
   logic [4:0]        w_scan_i, w_idx_next, w_res_pred;
   logic [DATA_W-1:0] w_cur, w_max_next;

   assign w_accept    = bus.sample_valid && r_ready;
   assign w_label_ok  = (r_label < 5'd30);
   assign w_scan_i    = (r_cnt < 8'd30) ? r_cnt[4:0] : 5'd0;
   assign w_scan_last = (r_cnt == 8'd29);
   assign w_cur       = bus.layer_out[w_scan_i];
   assign w_gt        = (w_cur > r_max);
   // first scan slot seeds the running max; strict compare keeps the lowest index on ties
   assign w_idx_next  = (r_cnt == 8'd0) ? 5'd0  : (w_gt ? w_scan_i : r_idx);
   assign w_max_next  = (r_cnt == 8'd0) ? w_cur : (w_gt ? w_cur : r_max);
   assign w_res_pred  = (r_state == c_ST_SCAN) ? w_idx_next : r_idx;

`ifdef TRAINER_SKIP_CORRECT_EN
   logic w_pred_hit;
   assign w_pred_hit = (w_idx_next == r_label);
   assign w_do_learn = r_train && w_label_ok && !w_pred_hit;
`else
   assign w_do_learn = r_train && w_label_ok;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:   if (w_accept) w_next = c_ST_DRIVE;
         c_ST_DRIVE:  w_next = c_ST_SETTLE;
         c_ST_SETTLE: if (r_cnt == 8'(SETTLE_CYCLES - 1)) w_next = c_ST_SCAN;
         c_ST_SCAN:   if (w_scan_last) w_next = w_do_learn ? c_ST_LEARN : c_ST_REPORT;
         c_ST_LEARN:  if (r_cnt == 8'(LEARN_CYCLES - 1)) w_next = c_ST_REPORT;
         c_ST_REPORT: w_next = c_ST_IDLE;
         default:     w_next = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= c_ST_IDLE;
         r_cnt         <= 8'd0;
         r_ready       <= 1'b0;
         r_label       <= 5'd0;
         r_train       <= 1'b0;
         r_max         <= '0;
         r_idx         <= 5'd0;
         r_res_valid   <= 1'b0;
         r_res_pred    <= 5'd0;
         r_res_correct <= 1'b0;
         r_res_err     <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
         r_ready     <= (w_next == c_ST_IDLE);
         r_res_valid <= (w_next == c_ST_REPORT);
         if (r_state == c_ST_IDLE && w_accept) begin
            r_label <= bus.sample_label;
            r_train <= bus.sample_train;
         end
         if (r_state == c_ST_SCAN) begin
            r_max <= w_max_next;
            r_idx <= w_idx_next;
         end
         // results are captured on REPORT entry and held until the next one
         if (w_next == c_ST_REPORT && r_state != c_ST_REPORT) begin
            r_res_pred    <= w_res_pred;
            r_res_correct <= w_label_ok && (w_res_pred == r_label);
            r_res_err     <= !w_label_ok;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sample_count  <= 16'd0;
         r_correct_count <= 16'd0;
      end else if (bus.clear_stats) begin
         r_sample_count  <= 16'd0;
         r_correct_count <= 16'd0;
      end else if (r_state == c_ST_REPORT) begin
         if (r_sample_count != 16'hFFFF)
            r_sample_count <= r_sample_count + 16'd1;
         if (r_res_correct && r_correct_count != 16'hFFFF)
            r_correct_count <= r_correct_count + 16'd1;
      end
   end

   generate
      for (genvar k = 0; k < 30; k++) begin : g_exp
         assign bus.layer_expected_out[k] =
            (r_state != c_ST_IDLE && r_label == 5'(k)) ? {DATA_W{1'b1}} : '0;
      end
   endgenerate

   assign bus.sample_ready     = r_ready;
   assign bus.layer_valid      = (r_state == c_ST_DRIVE) || (r_state == c_ST_LEARN);
   assign bus.layer_learn      = (r_state == c_ST_LEARN);
   assign bus.result_valid     = r_res_valid;
   assign bus.result_pred      = r_res_pred;
   assign bus.result_correct   = r_res_correct;
   assign bus.result_label_err = r_res_err;
   assign bus.sample_count     = r_sample_count;
   assign bus.correct_count    = r_correct_count;
endmodule

`default_nettype wire
